// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point adder/subtractor (IEEE-754 style).
//
// One operation is in flight at a time. Operands are captured on an accepted
// input handshake, then processed through ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Subnormal inputs are flushed to signed zero; rounding is round-to-nearest-even.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   op_a, op_b        operands {sign, exp, frac}
//   op_sub            1: A-B, 0: A+B (captured with the operands)
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   result            rounded result, held stable while out_valid & !out_ready
//   flags             {invalid, overflow, underflow, inexact}, valid with out_valid
//   o_dbg_state       current FSM state, for observation only
//
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and data is stable while valid is high.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] op_a,
    input  logic [EXP_W+MAN_W:0] op_b,
    input  logic                 op_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags,
    output logic [2:0]           o_dbg_state
);

    localparam int W   = EXP_W + MAN_W + 1;
    // Significand datapath: {carry, hidden, frac, G, R, S}
    localparam int SW  = MAN_W + 5;
    localparam int HID = SW - 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_ROUND = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [EXP_W-1:0] EXP_ZERO  = '0;
    localparam logic [EXP_W:0]   EXP_MAX   = {1'b0, EXP_ONES};
    localparam logic [EXP_W:0]   EXP_ONE   = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [MAN_W-1:0] FRAC_ZERO = '0;
    localparam logic [MAN_W-1:0] FRAC_QNAN = {1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, FRAC_QNAN};
    localparam logic [31:0]      ALIGN_LIM = 32'(MAN_W + 3);

    logic [2:0]     r_state;
    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;
    logic           r_sub;
    logic           r_special;
    logic           r_sign;     // sign of the larger magnitude (result sign)
    logic           r_sign_b;   // effective sign of the smaller operand
    logic [EXP_W:0] r_exp;
    logic [SW-1:0]  r_sig_a;    // larger significand, later the working result
    logic [SW-1:0]  r_sig_b;    // aligned smaller significand
    logic [W-1:0]   r_result;
    logic [3:0]     r_flags;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign result      = r_result;
    assign flags       = r_flags;
    assign o_dbg_state = r_state;

    // ---------------- ALIGN: unpack, classify, swap, align ----------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;

    assign w_sa = r_op_a[W-1];
    assign w_ea = r_op_a[W-2:MAN_W];
    assign w_fa = r_op_a[MAN_W-1:0];
    assign w_sb = r_op_b[W-1] ^ r_sub;
    assign w_eb = r_op_b[W-2:MAN_W];
    assign w_fb = r_op_b[MAN_W-1:0];

    logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

    assign w_a_nan  = (w_ea == EXP_ONES) && (w_fa != FRAC_ZERO);
    assign w_b_nan  = (w_eb == EXP_ONES) && (w_fb != FRAC_ZERO);
    assign w_a_inf  = (w_ea == EXP_ONES) && (w_fa == FRAC_ZERO);
    assign w_b_inf  = (w_eb == EXP_ONES) && (w_fb == FRAC_ZERO);
    // exp==0 covers both true zeros and flushed subnormals
    assign w_a_zero = (w_ea == EXP_ZERO);
    assign w_b_zero = (w_eb == EXP_ZERO);

    logic             w_swap;
    logic             w_s_big, w_s_small;
    logic [EXP_W-1:0] w_e_big, w_e_small, w_diff;
    logic [MAN_W-1:0] w_f_big, w_f_small;
    logic [SW-1:0]    w_sig_small, w_shifted, w_sig_b_al;
    logic             w_lost;

    assign w_swap      = {w_eb, w_fb} > {w_ea, w_fa};
    assign w_s_big     = w_swap ? w_sb : w_sa;
    assign w_s_small   = w_swap ? w_sa : w_sb;
    assign w_e_big     = w_swap ? w_eb : w_ea;
    assign w_e_small   = w_swap ? w_ea : w_eb;
    assign w_f_big     = w_swap ? w_fb : w_fa;
    assign w_f_small   = w_swap ? w_fa : w_fb;
    assign w_diff      = w_e_big - w_e_small;
    assign w_sig_small = {2'b01, w_f_small, 3'b000};

    always_comb begin
        w_shifted = w_sig_small >> w_diff;
        // Bits shifted below S collapse into the sticky bit.
        w_lost    = |(w_sig_small & ((SW'(1) << w_diff) - SW'(1)));
        if (32'(w_diff) >= ALIGN_LIM) begin
            w_sig_b_al = SW'(1);
        end else begin
            w_sig_b_al = w_shifted | SW'(w_lost);
        end
    end

    logic         w_spec;
    logic [W-1:0] w_spec_res;
    logic [3:0]   w_spec_flags;

    always_comb begin
        w_spec       = 1'b1;
        w_spec_res   = '0;
        w_spec_flags = 4'b0000;
        if (w_a_nan || w_b_nan) begin
            w_spec_res      = QNAN;
            w_spec_flags[3] = (w_a_nan && !w_fa[MAN_W-1]) || (w_b_nan && !w_fb[MAN_W-1]);
        end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            w_spec_res      = QNAN;
            w_spec_flags[3] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_res = {w_sa, w_ea, w_fa};
        end else if (w_b_inf) begin
            w_spec_res = {w_sb, w_eb, w_fb};
        end else if (w_a_zero && w_b_zero) begin
            w_spec_res = {w_sa & w_sb, EXP_ZERO, FRAC_ZERO};
        end else if (w_a_zero) begin
            w_spec_res = {w_sb, w_eb, w_fb};
        end else if (w_b_zero) begin
            w_spec_res = {w_sa, w_ea, w_fa};
        end else begin
            w_spec = 1'b0;
        end
    end

    // ---------------- ADD ----------------
    logic [SW-1:0] w_sum, w_dif;

    assign w_sum = r_sig_a + r_sig_b;
    // r_sig_a >= r_sig_b by construction, so this never wraps.
    assign w_dif = r_sig_a - r_sig_b;

    // ---------------- ROUND ----------------
    logic             w_g, w_r, w_s, w_lsb, w_inc;
    logic [MAN_W+1:0] w_mant;
    logic [EXP_W:0]   w_exp_r;
    logic [MAN_W-1:0] w_frac_r;

    assign w_lsb    = r_sig_a[3];
    assign w_g      = r_sig_a[2];
    assign w_r      = r_sig_a[1];
    assign w_s      = r_sig_a[0];
    assign w_inc    = w_g & (w_r | w_s | w_lsb);
    assign w_mant   = {1'b0, r_sig_a[HID:3]} + {{(MAN_W+1){1'b0}}, w_inc};
    assign w_exp_r  = r_exp + {{EXP_W{1'b0}}, w_mant[MAN_W+1]};
    assign w_frac_r = w_mant[MAN_W+1] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_sub     <= 1'b0;
            r_special <= 1'b0;
            r_sign    <= 1'b0;
            r_sign_b  <= 1'b0;
            r_exp     <= '0;
            r_sig_a   <= '0;
            r_sig_b   <= '0;
            r_result  <= '0;
            r_flags   <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op_a  <= op_a;
                        r_op_b  <= op_b;
                        r_sub   <= op_sub;
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_special <= w_spec;
                    r_result  <= w_spec_res;
                    r_flags   <= w_spec_flags;
                    r_sign    <= w_s_big;
                    r_sign_b  <= w_s_small;
                    r_exp     <= {1'b0, w_e_big};
                    r_sig_a   <= {2'b01, w_f_big, 3'b000};
                    r_sig_b   <= w_sig_b_al;
                    r_state   <= S_ADD;
                end
                S_ADD: begin
                    // Special results already sit in r_result; passing through
                    // this cycle gives every early-out path the same latency.
                    if (r_special) begin
                        r_state <= S_DONE;
                    end else if (r_sign == r_sign_b) begin
                        if (w_sum[SW-1]) begin
                            r_sig_a <= {1'b0, w_sum[SW-1:2], w_sum[1] | w_sum[0]};
                            r_exp   <= r_exp + EXP_ONE;
                        end else begin
                            r_sig_a <= w_sum;
                        end
                        r_state <= S_NORM;
                    end else if (w_dif == '0) begin
                        r_result <= {r_sign & r_sign_b, EXP_ZERO, FRAC_ZERO};
                        r_flags  <= 4'b0000;
                        r_state  <= S_DONE;
                    end else begin
                        r_sig_a <= w_dif;
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_sig_a[HID]) begin
                        r_state <= S_ROUND;
                    end else if (r_exp > EXP_ONE) begin
                        r_sig_a <= {r_sig_a[SW-2:0], 1'b0};
                        r_exp   <= r_exp - EXP_ONE;
                    end else begin
                        // Would need a subnormal result: flush to signed zero.
                        r_result <= {r_sign, EXP_ZERO, FRAC_ZERO};
                        r_flags  <= 4'b0011;
                        r_state  <= S_DONE;
                    end
                end
                S_ROUND: begin
                    if (w_exp_r >= EXP_MAX) begin
                        r_result <= {r_sign, EXP_ONES, FRAC_ZERO};
                        r_flags  <= 4'b0101;
                    end else begin
                        r_result <= {r_sign, w_exp_r[EXP_W-1:0], w_frac_r};
                        r_flags  <= {3'b000, w_g | w_r | w_s};
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Testbench for fp_addsub_seq (FP32 defaults): directed vectors with
// hand-computed results, queue-based scoreboard and a decoupled monitor.
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [2:0]  dbg_state;

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sub     (op_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    logic [3:0]  exp_flg_q[$];
    int          exp_lat_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // ---------------- monitor ----------------
    int   acc_cyc = 0;
    logic prev_ov = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_cyc = cyc + 1;
            if (out_valid && !prev_ov) begin
                check("output_expected", 32'(exp_lat_q.size() > 0), 32'd1);
                if (exp_lat_q.size() > 0)
                    check("latency", 32'(cyc - acc_cyc), 32'(exp_lat_q[0]));
            end
            if (out_valid && out_ready) begin
                check("result_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("result", result, exp_q.pop_front());
                    check("flags", 32'(flags), 32'(exp_flg_q.pop_front()));
                    void'(exp_lat_q.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] res, input logic [3:0] flg, input int lat,
                         input bit push);
        int t;
        if (push) begin
            exp_q.push_back(res);
            exp_flg_q.push_back(flg);
            exp_lat_q.push_back(lat);
        end
        @(posedge clk); #1;
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_in_time", 32'(t < 200), 32'd1);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [31:0] res, input logic [3:0] flg, input int lat);
        issue(a, b, sub, res, flg, lat, 1'b1);
        drain();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_flags", 32'(flags), 32'd0);
        rst = 1'b0;

        run(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 4);   // 1+1
        run(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 4'b0000, 5);   // 1.5-1, k=1
        run(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 2);   // exact zero
        run(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 4);   // tie to even
        run(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 4);   // tie, round up
        run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 4);   // overflow
        run(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 2);   // inf-inf
        run(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2);   // sNaN
        run(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 2);   // qNaN
        run(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 2);   // -0 + -0
        run(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 2);   // inf + 1
        run(32'h00000000, 32'h40400000, 1'b0, 32'h40400000, 4'b0000, 2);   // 0 + 3
        run(32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'b0000, 5);   // -1 + 0.5
        run(32'h40000000, 32'hC0400000, 1'b1, 32'h40A00000, 4'b0000, 4);   // 2 - (-3)
        run(32'h3F800000, 32'h3F7FC000, 1'b1, 32'h3A800000, 4'b0000, 14);  // k=10
        run(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 3);   // underflow flush

        // Backpressure: hold out_ready low in DONE while offering new operands.
        out_ready = 1'b0;
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 4, 1'b1);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("stall_reached_done", 32'(out_valid), 32'd1);
        op_a = 32'h3FC00000; op_b = 32'h3FC00000; op_sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_result", result, 32'h40000000);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (20) @(posedge clk);
        #1;
        check("stall_no_extra", 32'(out_valid), 32'd0);

        // Reset while the k=10 operation is normalising.
        issue(32'h3F800000, 32'h3F7FC000, 1'b1, 32'h0, 4'b0000, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_in_norm", 32'(dbg_state), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'h0);
        check("abort_flags", 32'(flags), 32'd0);
        t = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) t++;
        end
        check("abort_no_stale", 32'(t), 32'd0);

        // Operation after abort still works.
        run(32'h3FC00000, 32'h3F800000, 1'b0, 32'h40200000, 4'b0000, 4);   // 1.5+1

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
